// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// 4x4 keypad column scanner with full-matrix debounce; emits one one-hot code per clean single-key press.
// Latency: row -> accept <= (DEBOUNCE_SCANS+1) full scans + 1 cycle; outputs registered. No backpressure: key_valid is a strobe.
// Optional KEYPAD_HOLD_EN: onehot holds the accepted key while it stays pressed (level mode) instead of pulsing.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] onehot,
    output logic        key_valid,
    output logic [3:0]  key_code
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, ACTIVE, BLOCKED} state_e;

    logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [15:0]   snap_q, snap_d, prev_q, prev_d, deb_q, deb_d;
    logic [SW-1:0] stable_q, stable_d;
    state_e        state_q, state_d;
    logic [15:0]   onehot_q, onehot_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;

    logic          sample;
    logic [4:0]    deb_pop;
    logic [3:0]    deb_idx;
    logic          emit;

    always_comb begin
        row_s1_d = row;
        row_s2_d = row_s1_q;
    end

    // Rows are sampled on the last dwell cycle so the column drive has settled through the synchronizer.
    always_comb begin
        dwell_d   = dwell_q;
        col_idx_d = col_idx_q;
        snap_d    = snap_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        deb_d     = deb_q;
        sample    = (dwell_q == DWELL_LAST);
        if (sample) begin
            dwell_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            for (int r = 0; r < 4; r++) begin
                snap_d[{2'(r), col_idx_q}] = ~row_s2_q[r];
            end
            if (col_idx_q == 2'd3) begin
                if (snap_d == prev_q) begin
                    stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
                end else begin
                    stable_d = SW'(1);
                end
                prev_d = snap_d;
                if (stable_d == STABLE_MAX) begin
                    deb_d = snap_d;
                end
            end
        end else begin
            dwell_d = dwell_q + DW'(1);
        end
    end

    always_comb begin
        deb_pop = 5'($countones(deb_q));
        deb_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (deb_q[i]) begin
                deb_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (deb_pop == 5'd1) begin
                    state_d = ACTIVE;
                end else if (deb_pop > 5'd1) begin
                    state_d = BLOCKED;
                end
            end
            ACTIVE, BLOCKED: begin
                if (deb_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        emit        = (state_q == IDLE) && (deb_pop == 5'd1);
        key_valid_d = emit;
        key_code_d  = emit ? deb_idx : key_code_q;
`ifdef KEYPAD_HOLD_EN
        if (emit) begin
            onehot_d = deb_q;
        end else if (state_q == ACTIVE && deb_q != '0) begin
            onehot_d = onehot_q;
        end else begin
            onehot_d = '0;
        end
`else
        onehot_d = emit ? deb_q : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            dwell_q     <= '0;
            col_idx_q   <= '0;
            snap_q      <= '0;
            prev_q      <= '0;
            deb_q       <= '0;
            stable_q    <= '0;
            onehot_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            deb_q       <= deb_d;
            stable_q    <= stable_d;
            onehot_q    <= onehot_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign onehot    = onehot_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Bench for keypad_scanner: emulated key matrix, cycle-indexed reference model and scoreboard of accepted keys.
module tb_keypad_scanner;
    localparam int SD   = 4;
    localparam int DS   = 3;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] onehot;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .onehot(onehot), .key_valid(key_valid), .key_code(key_code)
    );

    // Passive matrix: a pressed key shorts its row to the driven-low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [3:0] idx_of(input logic [15:0] v);
        logic [3:0] k;
        k = '0;
        for (int i = 0; i < 16; i++) if (v[i]) k = 4'(i);
        return k;
    endfunction

    // Reference model: edge n (from reset release) samples column ((n-1)/SD)%4 on its last dwell
    // cycle, seeing the key state from two edges earlier; debounce and acceptance follow the rules directly.
    typedef struct packed {logic [15:0] oh; logic [3:0] code;} ev_t;
    ev_t q[$];
    int n, stable, st, c;
    logic [15:0] h1, h2, snap, prev, deb, held, exp_onehot;
    logic        exp_kv;
    logic [3:0]  exp_code;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; h1 = '0; h2 = '0; snap = '0; prev = '0; deb = '0; held = '0;
            stable = 0; st = 0; exp_onehot = '0; exp_kv = 1'b0; exp_code = '0;
        end else begin
            n = n + 1;
            exp_kv = 1'b0;
            if (st == 0) begin
                if ($countones(deb) == 1) begin
                    exp_kv = 1'b1;
                    held = deb;
                    exp_code = idx_of(deb);
                    q.push_back(ev_t'{deb, exp_code});
                    st = 1;
                end else if ($countones(deb) > 1) begin
                    st = 2;
                end
            end else if (deb == '0) begin
                st = 0;
            end
`ifdef KEYPAD_HOLD_EN
            exp_onehot = (st == 1) ? held : '0;
`else
            exp_onehot = exp_kv ? held : '0;
`endif
            if ((n - 1) % SD == SD - 1) begin
                c = ((n - 1) / SD) % 4;
                for (int r = 0; r < 4; r++) snap[r*4+c] = h2[r*4+c];
                if (c == 3) begin
                    if (snap == prev) stable = (stable < DS) ? stable + 1 : DS;
                    else stable = 1;
                    prev = snap;
                    if (stable == DS) deb = snap;
                end
            end
            h2 = h1;
            h1 = keys;
        end
    end

    int pulses = 0, oh_cycles = 0, last_pulse_cyc = 0;
    logic [15:0] last_oh = '0;
    logic [3:0]  last_code = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] ecol;
            ecol = ~(4'b0001 << ((n / SD) % 4));
            check("col", 32'(col), 32'(ecol));
            check("onehot", 32'(onehot), 32'(exp_onehot));
            check("key_valid", 32'(key_valid), 32'(exp_kv));
            check("key_code", 32'(key_code), 32'(exp_code));
            if (onehot != '0) oh_cycles++;
            if (key_valid) begin
                pulses++;
                last_oh = onehot;
                last_code = key_code;
                last_pulse_cyc = cyc;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got onehot %0h expected no pulse", onehot);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check("sb_onehot", 32'(onehot), 32'(e.oh));
                    check("sb_code", 32'(key_code), 32'(e.code));
                end
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while ((n % SCAN) != ph && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("phase_wait_timeout", 32'(k < 64), 32'd1);
    endtask

    initial begin : stim
        logic [3:0] seq [4];
        int p0, t0, oh0, r0, r1;
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;

        idle(3);
        check("rst_col", 32'(col), 32'hE);
        check("rst_onehot", 32'(onehot), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_code", 32'(key_code), 32'h0);
        rst_n = 1'b1;

        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("scan_seq", 32'(col), 32'(seq[(k / SD) % 4]));
        end

        // Single press, hold, release, re-press.
        idle($urandom_range(0, 15));
        p0 = pulses; oh0 = oh_cycles;
        keys = 16'h0040; t0 = cyc;
        idle(200);
        check("s2_pulses", 32'(pulses - p0), 32'd1);
        check("s2_onehot", 32'(last_oh), 32'h0040);
        check("s2_code", 32'(last_code), 32'd6);
        check("s2_latency_le_65", 32'((last_pulse_cyc - t0) <= 65), 32'd1);
`ifdef KEYPAD_HOLD_EN
        check("s6_level_cycles", 32'((oh_cycles - oh0) >= 130), 32'd1);
`else
        check("s2_pulse_width", 32'(oh_cycles - oh0), 32'd1);
`endif
        keys = '0;
        idle(100);
        check("s2_no_release_pulse", 32'(pulses - p0), 32'd1);
        keys = 16'h0040;
        idle(200);
        check("s2_repress", 32'(pulses - p0), 32'd2);
        keys = '0;
        idle(100);

        // Bounce, phased so no three consecutive scans agree on a press.
        wait_phase(SCAN - 1);
        p0 = pulses;
        for (int i = 0; i < 12; i++) begin
            keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            idle(10);
        end
        keys = '0;
        idle(100);
        check("s3_bounce_pulses", 32'(pulses - p0), 32'd0);

        // Two keys together, then a clean single key.
        p0 = pulses;
        keys = 16'h8001;
        idle(200);
        check("s4_multi_pulses", 32'(pulses - p0), 32'd0);
        keys = '0;
        idle(100);
        keys = 16'h0100;
        idle(200);
        check("s4_after_pulses", 32'(pulses - p0), 32'd1);
        check("s4_onehot", 32'(last_oh), 32'h0100);
        check("s4_code", 32'(last_code), 32'd8);
        keys = '0;
        idle(100);

        // Rollover.
        p0 = pulses;
        keys = 16'h0008;
        idle(200);
        check("s5_first", 32'(last_oh), 32'h0008);
        keys = 16'h0028;
        idle(200);
        check("s5_rollover_pulses", 32'(pulses - p0), 32'd1);
        keys = '0;
        idle(100);
        keys = 16'h0020;
        idle(200);
        check("s5_pulses", 32'(pulses - p0), 32'd2);
        check("s5_onehot", 32'(last_oh), 32'h0020);
        check("s5_code", 32'(last_code), 32'd5);
        keys = '0;
        idle(100);

        // Asynchronous reset in the middle of column 2's dwell.
        wait_phase(9);
        #2 rst_n = 1'b0;
        #1;
        check("arst_col", 32'(col), 32'hE);
        check("arst_onehot", 32'(onehot), 32'h0);
        check("arst_key_valid", 32'(key_valid), 32'h0);
        check("arst_key_code", 32'(key_code), 32'h0);
        idle(2);
        rst_n = 1'b1;

        // Random presses, single and double, checked against the model.
        for (int i = 0; i < 12; i++) begin
            r0 = $urandom_range(0, 15);
            r1 = $urandom_range(0, 15);
            keys = '0;
            keys[r0] = 1'b1;
            if ($urandom_range(0, 3) == 3) keys[r1] = 1'b1;
            idle($urandom_range(30, 200));
            keys = '0;
            idle($urandom_range(20, 120));
        end
        idle(100);
        check("sb_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
